// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two 32*WORDS-bit operands one limb per cycle through an external 32-bit adder
module wide_add_sequencer #(
    parameter int WORDS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   in_a,
    input  logic [32*WORDS-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   out_sum,
    output logic                  out_cout,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_cin,
    input  logic [31:0]           add_sum,
    input  logic                  add_cout
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;

    logic [1:0]          state;
    logic [IW-1:0]       idx;
    logic [32*WORDS-1:0] a_q, b_q, sum_q;
    logic                carry_q;
    logic                run;

    assign run       = (state == RUN);
    assign in_ready  = (state == IDLE) & ~rst;
    assign out_valid = (state == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;

    always_comb begin
        add_a   = run ? a_q[32*idx +: 32] : 32'd0;
        add_b   = run ? b_q[32*idx +: 32] : 32'd0;
        add_cin = run ? carry_q : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q     <= in_a;
                    b_q     <= in_b;
                    carry_q <= in_cin;
                    idx     <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    sum_q[32*idx +: 32] <= add_sum;
                    carry_q             <= add_cout;
                    if (idx == IW'(WORDS-1)) state <= DONE;
                    else idx <= idx + 1'b1;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer: directed checks of the limb sequencer with a behavioural 32-bit adder attached
module tb_wide_add_sequencer;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_ready, in_cin = 0;
    logic [63:0] in_a = 0, in_b = 0, out_sum;
    logic        out_valid, out_ready = 0, out_cout;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    int          checks = 0, errors = 0;

    wide_add_sequencer #(.WORDS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [63:0] va [3] = '{64'h1, 64'hFFFFFFFF_FFFFFFFF, 64'hDEADBEEF_00000000};
    logic [63:0] vb [3] = '{64'h2, 64'hFFFFFFFF_FFFFFFFF, 64'h21524111_FFFFFFFF};
    logic        vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [64:0] ref_r;

    initial begin
        #1;
        chk("rst_in_ready", 65'(in_ready), 65'(0));
        chk("rst_out_valid", 65'(out_valid), 65'(0));
        chk("rst_out_sum", 65'(out_sum), 65'(0));
        chk("rst_add_a", 65'({add_a, add_b, add_cin}), 65'(0));
        tick();
        tick();
        rst = 0;
        #1;
        chk("post_rst_in_ready", 65'(in_ready), 65'(1));

        // full carry ripple
        in_valid = 1; in_a = 64'hFFFFFFFF_FFFFFFFF; in_b = 64'h1; in_cin = 0;
        tick();
        in_valid = 0;
        chk("ripple_run0_in_ready", 65'(in_ready), 65'(0));
        chk("ripple_run0_add_a", 65'(add_a), 65'(32'hFFFFFFFF));
        chk("ripple_run0_valid", 65'(out_valid), 65'(0));
        tick();
        chk("ripple_run1_valid", 65'(out_valid), 65'(0));
        chk("ripple_run1_add_cin", 65'(add_cin), 65'(1));
        tick();
        chk("ripple_valid", 65'(out_valid), 65'(1));
        chk("ripple_sum", 65'(out_sum), 65'(0));
        chk("ripple_cout", 65'(out_cout), 65'(1));
        chk("done_add_zero", 65'({add_a, add_b, add_cin}), 65'(0));
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("ripple_idle_valid", 65'(out_valid), 65'(0));
        chk("ripple_hold_cout", 65'(out_cout), 65'(1));
        chk("ripple_idle_ready", 65'(in_ready), 65'(1));

        // inter-limb carry
        in_valid = 1; in_a = 64'h00000000_FFFFFFFF; in_b = 64'h1; in_cin = 0;
        tick();
        in_valid = 0;
        chk("limb_run0_add", 65'({add_a, add_b, add_cin}), 65'({32'hFFFFFFFF, 32'h1, 1'b0}));
        tick();
        chk("limb_run1_add_cin", 65'(add_cin), 65'(1));
        chk("limb_run1_add_a", 65'(add_a), 65'(0));
        chk("limb_run1_add_b", 65'(add_b), 65'(0));
        tick();
        chk("limb_sum", 65'(out_sum), 65'(64'h00000001_00000000));
        chk("limb_cout", 65'(out_cout), 65'(0));
        out_ready = 1;
        tick();
        out_ready = 0;

        // carry-in only
        in_valid = 1; in_a = 0; in_b = 0; in_cin = 1;
        tick();
        in_valid = 0; in_cin = 0;
        chk("cin_run0_add_cin", 65'(add_cin), 65'(1));
        tick();
        tick();
        chk("cin_valid", 65'(out_valid), 65'(1));
        chk("cin_sum", 65'(out_sum), 65'(64'h1));
        chk("cin_cout", 65'(out_cout), 65'(0));
        out_ready = 1;
        tick();
        out_ready = 0;

        // backpressure with a competing request
        in_valid = 1; in_a = 64'h12345678_9ABCDEF0; in_b = 64'h11111111_11111111;
        tick();
        in_a = 64'h5; in_b = 64'h7;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 65'(out_valid), 65'(1));
            chk("bp_sum", 65'(out_sum), 65'(64'h23456789_ABCDF001));
            chk("bp_cout", 65'(out_cout), 65'(0));
            chk("bp_in_ready", 65'(in_ready), 65'(0));
            tick();
        end
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
        chk("bp_release_ready", 65'(in_ready), 65'(1));
        chk("bp_release_valid", 65'(out_valid), 65'(0));

        // asynchronous reset during the first RUN cycle
        in_valid = 1; in_a = 64'hFFFFFFFF_FFFFFFFF; in_b = 64'h1;
        tick();
        in_valid = 0;
        chk("mid_run_add_a", 65'(add_a), 65'(32'hFFFFFFFF));
        rst = 1;
        #1;
        chk("arst_valid", 65'(out_valid), 65'(0));
        chk("arst_sum", 65'(out_sum), 65'(0));
        chk("arst_add", 65'({add_a, add_b, add_cin}), 65'(0));
        chk("arst_in_ready", 65'(in_ready), 65'(0));
        tick();
        rst = 0;
        #1;
        chk("arst_release_ready", 65'(in_ready), 65'(1));
        tick();
        tick();
        tick();
        chk("arst_no_stale_valid", 65'(out_valid), 65'(0));
        chk("arst_no_stale_sum", 65'(out_sum), 65'(0));

        // back-to-back with out_ready held high
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_a = va[i]; in_b = vb[i]; in_cin = vc[i];
            ref_r = {1'b0, va[i]} + {1'b0, vb[i]} + {64'd0, vc[i]};
            chk("b2b_accept_ready", 65'(in_ready), 65'(1));
            tick();
            chk("b2b_run_ready", 65'(in_ready), 65'(0));
            tick();
            chk("b2b_run1_valid", 65'(out_valid), 65'(0));
            tick();
            chk("b2b_valid", 65'(out_valid), 65'(1));
            chk("b2b_sum", 65'(out_sum), 65'(ref_r[63:0]));
            chk("b2b_cout", 65'(out_cout), 65'(ref_r[64]));
            chk("b2b_done_ready", 65'(in_ready), 65'(0));
            tick();
        end
        in_valid = 0; out_ready = 0;
        chk("b2b_end_idle", 65'(in_ready), 65'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-limb adder sequencer that adds two `32*WORDS`-bit operands using one external 32-bit ripple adder stage, one limb per cycle. The sequencer feeds the adder's `A`/`B`/`Cin` inputs and consumes its `Sum`/`Cout` outputs, chaining `Cout` back into `Cin` on each step. It accepts operands through a valid/ready handshake and presents the full-width sum and final carry through a second valid/ready handshake.

## Interface
Parameters:
- `WORDS`, default 2: number of 32-bit limbs. Must be 1 or more. Operand width is `32*WORDS`.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: operand request.
- `in_ready`, output, 1: sequencer can accept operands.
- `in_a`, input, `32*WORDS`: operand A.
- `in_b`, input, `32*WORDS`: operand B.
- `in_cin`, input, 1: carry into limb 0.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: downstream takes the result.
- `out_sum`, output, `32*WORDS`: full-width sum.
- `out_cout`, output, 1: carry out of the top limb.
- `add_a`, output, 32: to adder `A`.
- `add_b`, output, 32: to adder `B`.
- `add_cin`, output, 1: to adder `Cin`.
- `add_sum`, input, 32: from adder `Sum`.
- `add_cout`, input, 1: from adder `Cout`.

## Operation
- States: `IDLE`, `RUN`, `DONE`. The state register, limb index `idx` (width `$clog2(WORDS)`, minimum 1), operand registers, carry register, and sum register are all cleared by `rst`.
- `IDLE`:
  - `in_ready=1` (forced to 0 while `rst` is high).
  - When `in_valid & in_ready`: capture `in_a`/`in_b` into `a_q`/`b_q`, set `carry_q <= in_cin`, `idx <= 0`, go to `RUN`.
- `RUN`:
  - Drives `add_a = a_q[32*idx +: 32]`, `add_b = b_q[32*idx +: 32]`, `add_cin = carry_q`.
  - Each edge: `sum_q[32*idx +: 32] <= add_sum`, `carry_q <= add_cout`.
  - If `idx == WORDS-1`, go to `DONE`; otherwise `idx <= idx+1`.
- `DONE`:
  - `out_valid=1`, `out_sum = sum_q`, `out_cout = carry_q`.
  - When `out_ready`: go to `IDLE`.
- `add_a`, `add_b`, `add_cin` are 0 in `IDLE` and `DONE`. The external adder is purely combinational; no adder latency is assumed beyond a single cycle.
- `in_ready=0` in `RUN` and `DONE`. Operations never overlap, and `in_valid` is ignored outside `IDLE`.
- Arithmetic is unsigned modulo `2^(32*WORDS)`; the overflow indication is `out_cout`.
- `out_sum` and `out_cout` hold their last values after a handshake until the next operation overwrites limbs.
- `WORDS=1` degenerates to a single `RUN` cycle.

## Timing
- Reset values: `in_ready=0` while `rst` is high and 1 afterwards; `out_valid=0`; `out_sum=0`; `out_cout=0`; `add_a=0`; `add_b=0`; `add_cin=0`.
- Accept at edge N. `RUN` covers edges N+1 to N+WORDS. `out_valid` rises after edge N+WORDS, giving a latency of WORDS cycles.
- With `out_ready` tied high: `DONE` lasts 1 cycle, `IDLE` is re-entered after edge N+WORDS+1, and the next accept occurs at edge N+WORDS+2 at the earliest. Throughput is one operation per WORDS+2 cycles.
- Backpressure: `out_valid`, `out_sum`, and `out_cout` stay stable for as long as `out_ready=0`.
- `rst` asserted in any state immediately clears all registers and outputs and returns the block to `IDLE`. A partial result is discarded and `out_valid` is never raised for it.
- `out_ready` high outside `DONE` has no effect.

## Test plan
- Full carry ripple (WORDS=2): `in_a=64'hFFFFFFFF_FFFFFFFF`, `in_b=64'h1`, `in_cin=0` -> `out_sum=0`, `out_cout=1`; `out_valid` rises 2 cycles after the accept edge.
- Inter-limb carry: `in_a=64'h00000000_FFFFFFFF`, `in_b=64'h1`, `in_cin=0` -> `out_sum=64'h00000001_00000000`, `out_cout=0`. During the second `RUN` cycle, the bench checks `add_cin=1`, `add_a=0`, `add_b=0`.
- Carry-in only: `in_a=0`, `in_b=0`, `in_cin=1` -> `out_sum=64'h1`, `out_cout=0`. During the first `RUN` cycle, `add_cin=1`.
- Backpressure: result of `64'h12345678_9ABCDEF0 + 64'h11111111_11111111`, with `out_ready=0` for 5 cycles -> `out_valid` held at 1, `out_sum=64'h23456789_ABCDF001` stable, `in_ready=0`. A concurrent `in_valid` is not accepted.
- Reset mid-operation: assert `rst` during the first `RUN` cycle -> `out_valid`, `out_sum`, `add_*`, and `in_ready` go to 0 without waiting for a clock edge. After release, `in_ready=1` and no stale result appears.
- Back-to-back: `in_valid` and `out_ready` held high with 3 operand pairs -> accepts every 4 cycles, and all 3 results match a reference model in order.
